// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port (requesters A and B).
// Optional post-reset clear of registers 1..2**AW-1 is enabled by defining REGFILE_ARB_INIT_EN.
module regfile_write_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          Clk,
  input  logic          ResetN,
  input  logic          ReqValidA,
  input  logic [AW-1:0] ReqAddrA,
  input  logic [DW-1:0] ReqDataA,
  output logic          ReqReadyA,
  input  logic          ReqValidB,
  input  logic [AW-1:0] ReqAddrB,
  input  logic [DW-1:0] ReqDataB,
  output logic          ReqReadyB,
  output logic [AW-1:0] WriteRegister,
  output logic [DW-1:0] WriteData,
  output logic          RegWrite,
  output logic          InitDone,
  output logic          LastGrantB
);

  logic          run;
  logic          ptr_b, ptr_nxt;
  logic          gnt_a, gnt_b;
  logic          we_nxt, lgb_nxt;
  logic [AW-1:0] addr_nxt;
  logic [DW-1:0] data_nxt;

`ifdef REGFILE_ARB_INIT_EN
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state <= S_INIT;
      cnt   <= AW'(1);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == S_INIT) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt == '1) state_nxt = S_RUN;
    end
  end

  assign run = (state == S_RUN);
`else
  assign run = 1'b1;
`endif

  assign InitDone = run;

  // Contention is resolved by the pointer; a lone requester always wins.
  always_comb begin
    gnt_a = ReqValidA && (!ReqValidB || !ptr_b);
    gnt_b = ReqValidB && (!ReqValidA || ptr_b);
  end

  assign ReqReadyA = ResetN && run && gnt_a;
  assign ReqReadyB = ResetN && run && gnt_b;

  always_comb begin
    we_nxt   = 1'b0;
    addr_nxt = WriteRegister;
    data_nxt = WriteData;
    lgb_nxt  = LastGrantB;
    ptr_nxt  = ptr_b;
    if (ReqReadyA || ReqReadyB) begin
      addr_nxt = ReqReadyB ? ReqAddrB : ReqAddrA;
      data_nxt = ReqReadyB ? ReqDataB : ReqDataA;
      // Register 0 is hardwired: handshake completes but no write is issued.
      we_nxt   = (addr_nxt != '0);
      lgb_nxt  = ReqReadyB;
      if (ReqValidA && ReqValidB) ptr_nxt = !ptr_b;
    end
`ifdef REGFILE_ARB_INIT_EN
    if (!run) begin
      we_nxt   = 1'b1;
      addr_nxt = cnt;
      data_nxt = '0;
    end
`endif
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      LastGrantB    <= 1'b0;
      ptr_b         <= 1'b0;
    end else begin
      RegWrite      <= we_nxt;
      WriteRegister <= addr_nxt;
      WriteData     <= data_nxt;
      LastGrantB    <= lgb_nxt;
      ptr_b         <= ptr_nxt;
    end
  end

endmodule
